// File: rtl/sobel_mag_pipe_if.sv
// Handshake/bus bundle for sobel_mag_pipe: window input side and magnitude output side.
// Ports: in_valid/in_ready/mode/el1..el9 (window in), out_valid/out_ready/mag/gx/gy (result out).
// Optional SOBEL_MAG_THRESH_EN adds thresh (with window) and edge_hit (with result).
interface sobel_mag_pipe_if #(
    parameter int PIX_W = 8
);
    localparam int MAG_W = PIX_W + 3;

    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;       // 0 = L2 magnitude, 1 = L1 magnitude
    logic [PIX_W-1:0]        el1, el2, el3, el4, el5, el6, el7, el8, el9;
    logic                    out_valid;
    logic                    out_ready;
    logic [MAG_W-1:0]        mag;
    logic signed [MAG_W-1:0] gx;
    logic signed [MAG_W-1:0] gy;
`ifdef SOBEL_MAG_THRESH_EN
    logic [MAG_W-1:0]        thresh;
    // 'edge' is a reserved word, so the edge flag is named edge_hit
    logic                    edge_hit;
`endif

    // master: window producer + result consumer
    modport master (
        output in_valid, mode, el1, el2, el3, el4, el5, el6, el7, el8, el9, out_ready,
`ifdef SOBEL_MAG_THRESH_EN
        output thresh,
        input  edge_hit,
`endif
        input  in_ready, out_valid, mag, gx, gy
    );

    // slave: the magnitude engine
    modport slave (
        input  in_valid, mode, el1, el2, el3, el4, el5, el6, el7, el8, el9, out_ready,
`ifdef SOBEL_MAG_THRESH_EN
        input  thresh,
        output edge_hit,
`endif
        output in_ready, out_valid, mag, gx, gy
    );
endinterface

// File: rtl/sobel_mag_pipe.sv
// Pipelined Sobel edge magnitude: Gx/Gy, then floor-L2 (non-restoring sqrt) or L1 magnitude.
// Latency 3+MAG_W advancing cycles (14 for PIX_W=8); one window per cycle throughput.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk, rst (sync, active-high), io (sobel_mag_pipe_if.slave). Optional macro SOBEL_MAG_THRESH_EN.
module sobel_mag_pipe #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sobel_mag_pipe_if.slave  io
);
    localparam int MAG_W = PIX_W + 3;

    // One non-restoring sqrt iteration: shift in two radicand bits, add or subtract
    // the trial term depending on the remainder sign, then append one root bit.
    // Returns {remainder, root}.
    function automatic logic [2*MAG_W+1:0] sqrt_step(
        input logic signed [MAG_W+1:0] r,
        input logic [MAG_W-1:0]        q,
        input logic [1:0]              d
    );
        logic signed [MAG_W+1:0] rs;
        logic signed [MAG_W+1:0] rn;
        logic [MAG_W-1:0]        qn;
        rs = {r[MAG_W-1:0], d};
        if (!r[MAG_W+1]) rn = rs - {q, 2'b01};
        else             rn = rs + {q, 2'b11};
        qn = {q[MAG_W-2:0], ~rn[MAG_W+1]};
        return {rn, qn};
    endfunction

    function automatic logic signed [MAG_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic adv;
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    // stage 1: gradients
    logic                    v1, m1;
    logic signed [MAG_W-1:0] gx1, gy1, gx_c, gy_c;
    // stage 2: squared sum and L1 sum
    logic                    v2, m2;
    logic signed [MAG_W-1:0] gx2, gy2;
    logic [2*MAG_W-1:0]      sq2, sq_c;
    logic [MAG_W-1:0]        l12, l1_c, ax, ay;
    // sqrt stages: index 0 is the radicand stage, index MAG_W is the output register
    logic                    sv   [0:MAG_W];
    logic signed [MAG_W-1:0] sgx  [0:MAG_W];
    logic signed [MAG_W-1:0] sgy  [0:MAG_W];
    logic [MAG_W-1:0]        sq_q [0:MAG_W];
    logic                    sm   [0:MAG_W-1];
    logic signed [MAG_W+1:0] sr   [0:MAG_W-1];
    logic [2*MAG_W-1:0]      srad [0:MAG_W-1];
    logic signed [MAG_W+1:0] nr   [1:MAG_W];
    logic [MAG_W-1:0]        nq   [1:MAG_W];

    assign gx_c = ext(io.el3) + (ext(io.el6) <<< 1) + ext(io.el9)
                - ext(io.el1) - (ext(io.el4) <<< 1) - ext(io.el7);
    assign gy_c = ext(io.el7) + (ext(io.el8) <<< 1) + ext(io.el9)
                - ext(io.el1) - (ext(io.el2) <<< 1) - ext(io.el3);

    // |G| <= 4*(2^PIX_W-1), so the negation never overflows MAG_W bits
    assign ax   = gx1[MAG_W-1] ? MAG_W'(-gx1) : MAG_W'(gx1);
    assign ay   = gy1[MAG_W-1] ? MAG_W'(-gy1) : MAG_W'(gy1);
    assign sq_c = {{MAG_W{1'b0}}, ax} * {{MAG_W{1'b0}}, ax}
                + {{MAG_W{1'b0}}, ay} * {{MAG_W{1'b0}}, ay};
    assign l1_c = ax + ay;

    // L1 windows hold their preloaded result unchanged through the sqrt stages
    always_comb begin
        for (int j = 1; j <= MAG_W; j++) begin
            {nr[j], nq[j]} = sm[j-1] ? {sr[j-1], sq_q[j-1]}
                                     : sqrt_step(sr[j-1], sq_q[j-1], srad[j-1][2*(MAG_W-j) +: 2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;  m1  <= 1'b0;  gx1 <= '0;  gy1 <= '0;
            v2  <= 1'b0;  m2  <= 1'b0;  gx2 <= '0;  gy2 <= '0;
            sq2 <= '0;    l12 <= '0;
            for (int j = 0; j <= MAG_W; j++) begin
                sv[j] <= 1'b0;  sgx[j] <= '0;  sgy[j] <= '0;  sq_q[j] <= '0;
            end
            for (int j = 0; j < MAG_W; j++) begin
                sm[j] <= 1'b0;  sr[j] <= '0;  srad[j] <= '0;
            end
        end else if (adv) begin
            v1  <= io.in_valid;  m1  <= io.mode;  gx1 <= gx_c;  gy1 <= gy_c;
            v2  <= v1;  m2  <= m1;  gx2 <= gx1;  gy2 <= gy1;
            sq2 <= sq_c;  l12 <= l1_c;
            sv[0]   <= v2;   sm[0]  <= m2;   sgx[0] <= gx2;  sgy[0] <= gy2;
            srad[0] <= sq2;  sr[0]  <= '0;
            sq_q[0] <= m2 ? l12 : '0;
            for (int j = 1; j <= MAG_W; j++) begin
                sv[j]   <= sv[j-1];
                sgx[j]  <= sgx[j-1];
                sgy[j]  <= sgy[j-1];
                sq_q[j] <= nq[j];
            end
            for (int j = 1; j < MAG_W; j++) begin
                sm[j]   <= sm[j-1];
                sr[j]   <= nr[j];
                srad[j] <= srad[j-1];
            end
        end
    end

    assign io.out_valid = sv[MAG_W];
    assign io.mag       = sq_q[MAG_W];
    assign io.gx        = sgx[MAG_W];
    assign io.gy        = sgy[MAG_W];

`ifdef SOBEL_MAG_THRESH_EN
    logic [MAG_W-1:0] th1, th2;
    logic [MAG_W-1:0] sth [0:MAG_W-1];
    logic             edge_q;

    // threshold rides alongside its window; the compare uses the final root value
    always_ff @(posedge clk) begin
        if (rst) begin
            th1 <= '0;  th2 <= '0;  edge_q <= 1'b0;
            for (int j = 0; j < MAG_W; j++) sth[j] <= '0;
        end else if (adv) begin
            th1    <= io.thresh;
            th2    <= th1;
            sth[0] <= th2;
            for (int j = 1; j < MAG_W; j++) sth[j] <= sth[j-1];
            edge_q <= (nq[MAG_W] >= sth[MAG_W-1]);
        end
    end

    assign io.edge_hit = edge_q;
`endif
endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Self-checking bench for sobel_mag_pipe: directed windows, latency, stall stream, mid-flight reset.
// Latency under test: 14 advancing cycles for PIX_W=8.
// Backpressure exercised with pseudo-random out_ready in the stream section.
module tb_sobel_mag_pipe;
    localparam int PIX_W = 8;
    localparam int MAG_W = PIX_W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_mag_pipe_if #(.PIX_W(PIX_W)) io();
    sobel_mag_pipe #(.PIX_W(PIX_W)) dut (.clk(clk), .rst(rst), .io(io));

    int n_assert = 0;
    int n_fail   = 0;
    int w [1:9];
    int qgx[$], qgy[$], qmag[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
        w[1] = a1; w[2] = a2; w[3] = a3; w[4] = a4; w[5] = a5;
        w[6] = a6; w[7] = a7; w[8] = a8; w[9] = a9;
    endtask

    task automatic apply_win(input bit m);
        io.el1 = w[1][PIX_W-1:0]; io.el2 = w[2][PIX_W-1:0]; io.el3 = w[3][PIX_W-1:0];
        io.el4 = w[4][PIX_W-1:0]; io.el5 = w[5][PIX_W-1:0]; io.el6 = w[6][PIX_W-1:0];
        io.el7 = w[7][PIX_W-1:0]; io.el8 = w[8][PIX_W-1:0]; io.el9 = w[9][PIX_W-1:0];
        io.mode = m;
    endtask

    function automatic int ref_gx();
        return w[3] + 2*w[6] + w[9] - w[1] - 2*w[4] - w[7];
    endfunction

    function automatic int ref_gy();
        return w[7] + 2*w[8] + w[9] - w[1] - 2*w[2] - w[3];
    endfunction

    function automatic int ref_mag(input int gx, input int gy, input bit m);
        int ax, ay, s, r;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (m) return ax + ay;
        s = ax*ax + ay*ay;
        r = 0;
        while ((r+1)*(r+1) <= s) r++;
        return r;
    endfunction

    // Called at a negedge with an empty-ready pipe and out_ready=1; checks exact latency.
    task automatic run_one(input string tag, input bit m, input int egx, input int egy, input int emag);
        int early;
        early = 0;
        apply_win(m);
        io.in_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) io.in_valid = 1'b0;
            if (k < 14 && io.out_valid) early++;
        end
        check({tag, "_early"}, early, 0);
        check({tag, "_valid"}, 32'(io.out_valid), 1);
        check({tag, "_gx"},    32'($signed(io.gx)), egx);
        check({tag, "_gy"},    32'($signed(io.gy)), egy);
        check({tag, "_mag"},   32'(io.mag), emag);
        @(negedge clk);
        check({tag, "_oneshot"}, 32'(io.out_valid), 0);
    endtask

    initial begin
        int sent, got, cyc, extra, e_gx, e_gy, e_mag;
        bit pend, stalled;
        logic [MAG_W-1:0]        hmag;
        logic signed [MAG_W-1:0] hgx;

        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        set_w(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_win(1'b0);
`ifdef SOBEL_MAG_THRESH_EN
        io.thresh = MAG_W'(600);
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(io.out_valid), 0);
        check("rst_mag",       32'(io.mag), 0);
        check("rst_gx",        32'($signed(io.gx)), 0);
        check("rst_gy",        32'($signed(io.gy)), 0);
        check("rst_in_ready",  32'(io.in_ready), 1);
`ifdef SOBEL_MAG_THRESH_EN
        check("rst_edge",      32'(io.edge_hit), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(io.in_ready), 1);

        // directed windows
        set_w(77, 77, 77, 77, 77, 77, 77, 77, 77);
        run_one("flat", 1'b0, 0, 0, 0);
        set_w(0, 0, 255, 0, 0, 255, 0, 0, 255);
        run_one("vert_l2", 1'b0, 1020, 0, 1020);
        run_one("vert_l1", 1'b1, 1020, 0, 1020);
        set_w(0, 0, 100, 0, 0, 100, 100, 100, 100);
        run_one("c100_l2", 1'b0, 300, 300, 424);
        run_one("c100_l1", 1'b1, 300, 300, 600);
        set_w(0, 0, 255, 0, 0, 255, 255, 255, 255);
        run_one("c255_l1", 1'b1, 765, 765, 1530);
        run_one("c255_l2", 1'b0, 765, 765, 1081);

        // random stream with back-pressure
        sent = 0; got = 0; cyc = 0; pend = 1'b0; stalled = 1'b0;
        hmag = '0; hgx = '0;
        while (got < 20 && cyc < 3000) begin
            if (stalled) begin
                check("stall_hold_mag", 32'(io.mag), 32'(hmag));
                check("stall_hold_gx",  32'($signed(io.gx)), 32'(hgx));
            end
            io.out_ready = ($urandom_range(0, 2) != 0);
            if (!pend && sent < 20 && $urandom_range(0, 4) != 0) begin
                for (int i = 1; i <= 9; i++) w[i] = int'($urandom_range(0, 255));
                apply_win(sent[0]);
                pend = 1'b1;
            end
            io.in_valid = pend;
            #1;
            if (io.in_valid && io.in_ready) begin
                e_gx = ref_gx();
                e_gy = ref_gy();
                qgx.push_back(e_gx);
                qgy.push_back(e_gy);
                qmag.push_back(ref_mag(e_gx, e_gy, sent[0]));
                pend = 1'b0;
                sent++;
            end
            if (io.out_valid && io.out_ready) begin
                if (qmag.size() == 0) begin
                    check("stream_extra_out", 1, 0);
                end else begin
                    e_gx  = qgx.pop_front();
                    e_gy  = qgy.pop_front();
                    e_mag = qmag.pop_front();
                    check("stream_gx",  32'($signed(io.gx)), e_gx);
                    check("stream_gy",  32'($signed(io.gy)), e_gy);
                    check("stream_mag", 32'(io.mag), e_mag);
`ifdef SOBEL_MAG_THRESH_EN
                    check("stream_edge", 32'(io.edge_hit), 32'(e_mag >= 600));
`endif
                    got++;
                end
            end
            stalled = io.out_valid && !io.out_ready;
            hmag = io.mag;
            hgx  = io.gx;
            cyc++;
            @(negedge clk);
        end
        check("stream_count", got, 20);
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (io.out_valid) extra++;
        end
        check("stream_no_extra", extra, 0);

        // reset with 5 windows in flight
        for (int i = 1; i <= 5; i++) begin
            set_w(0, 0, 10*i, 0, 0, 0, 0, 0, 0);
            apply_win(1'b0);
            io.in_valid = 1'b1;
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(io.out_valid), 0);
        set_w(0, 0, 255, 0, 0, 255, 0, 0, 255);
        run_one("after_rst", 1'b1, 1020, 0, 1020);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (io.out_valid) extra++;
        end
        check("after_rst_no_ghost", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_mag_pipe.md
Name: sobel_mag_pipe

Overview:
- Fully pipelined, parametrised Sobel edge-magnitude engine; successor to the single-cycle sobel block.
- Accepts one 3x3 pixel window per cycle over a valid/ready handshake. Computes Gx/Gy, then either exact floor-L2 magnitude (bit-serial non-restoring sqrt unrolled across pipeline stages) or L1 magnitude |Gx|+|Gy|.
- Sits between the line-buffer/window generator and the edge-map writer; supports back-pressure.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned); legal 4..12.
- MAG_W, PIX_W+3, output magnitude width; derived, must not be overridden.
- LAT, 3+MAG_W, fixed input-to-output latency in advancing cycles (14 for PIX_W=8).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  window present on el1..el9.
- in_ready  out  1  block accepts window this cycle.
- mode  in  1  0 = L2 (sqrt(Gx^2+Gy^2)), 1 = L1 (|Gx|+|Gy|); sampled with the window.
- el1..el9  in  PIX_W each  window row-major, el1 top-left, el9 bottom-right.
- out_valid  out  1  magnitude valid.
- out_ready  in  1  downstream accepts.
- mag  out  MAG_W  magnitude.
- gx, gy  out  MAG_W signed each  raw gradients aligned with mag.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset: out_valid=0, mag=0, gx=0, gy=0, all internal stage valid bits=0. in_ready is combinational and reads 1 during/after reset.
- Reset mid-operation discards all in-flight windows; no output for them.
- Pipeline advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - On adv=0 every stage, including out regs, holds; mag/gx/gy stay stable while out_valid && !out_ready.
- Stage 1:
  - Gx = el3+2*el6+el9-el1-2*el4-el7.
  - Gy = el7+2*el8+el9-el1-2*el2-el3.
  - Both signed MAG_W bits, no overflow: |G| <= 4*(2^PIX_W-1).
  - mode and valid captured alongside.
- Stage 2: sq = Gx^2+Gy^2 (unsigned, 2*MAG_W bits); l1 = |Gx|+|Gy| (max 8*(2^PIX_W-1), fits MAG_W).
- Stage 3: radicand register selected by mode. L1 path bypasses sqrt arithmetic but still traverses the stages for equal latency.
- Stages 4..3+MAG_W: one result bit per stage, MSB first.
  - Non-restoring sqrt; remainder MAG_W+2 bits signed; root is floor(sqrt(sq)).
- Output: mag, gx, gy, out_valid registered; exactly LAT advancing cycles after input transfer.
- Ordering strictly FIFO. Throughput one window per cycle when out_ready=1.
- Bubbles (in_valid=0) propagate as invalid stages; they do not stall.
- mode may change every cycle; each window uses its own sampled mode.
- No internal state beyond the pipeline; no accumulation across windows.

Optional Feature:
- Macro SOBEL_MAG_THRESH_EN.
- Defined: adds input thresh (MAG_W) and output edge (1).
  - thresh is sampled with the window and carried down the pipe.
  - edge = (mag >= thresh) for that window; edge resets to 0 and holds under stall like mag.
- Undefined: thresh and edge ports do not exist; behaviour otherwise identical.

Test Plan:
- Flat window, all el=77, mode=0 -> after 14 cycles mag=0, gx=0, gy=0, out_valid=1 for exactly one cycle.
- el3=el6=el9=255, others 0, mode=0 -> gx=1020, gy=0, mag=1020; same window with mode=1 -> mag=1020.
- el3=el6=el7=el8=el9=100, others 0 -> gx=300, gy=300; mode=0 mag=424; mode=1 mag=600.
- el3=el6=el7=el8=el9=255, others 0, mode=1 -> gx=765, gy=765, mag=1530; mode=0 mag=1081.
- Stream 20 random windows with alternating mode, out_ready toggled pseudo-randomly -> outputs in order, none lost/duplicated, all match reference model, mag held stable while stalled; with SOBEL_MAG_THRESH_EN, thresh=600 flags edge=1 exactly on windows with mag>=600.
- Assert rst for one cycle with 5 windows in flight -> out_valid=0 next cycle, none of the 5 ever emerge, next accepted window appears after 14 cycles.
